// File: rtl/recon_tx_framer.sv
// recon_tx_framer: builds a TX frame of 46-byte template + 10-byte recon header
// followed by optional DMA readback payload, shifted up by 56 bytes so the
// payload packs tightly behind the headers on a 512-bit stream.
module recon_tx_framer #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int ADDR_WIDTH = 34,
    parameter int LEN_WIDTH  = 32,
    parameter int TMPL_BYTES = 46
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TMPL_BYTES*8-1:0] hdr_template,
    input  logic [1:0]              cmd_func,
    input  logic [7:0]              cmd_id,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_size,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    len_err,
    output logic                    busy
);
    // Each payload beat contributes its low 8 bytes to the current output
    // beat; the remaining 56 bytes ride in the carry into the next one.
    localparam int LEAD_BYTES  = 8;
    localparam int CARRY_BYTES = KEEP_WIDTH - LEAD_BYTES;
    localparam int LEAD_W      = LEAD_BYTES * 8;

    typedef enum logic [1:0] {IDLE, HDR, BODY, TAIL} state_t;

    state_t                     state_q, state_d;
    logic [TMPL_BYTES*8-1:0]    tmpl_q, tmpl_d;
    logic [1:0]                 func_q, func_d;
    logic [7:0]                 id_q, id_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [LEN_WIDTH-1:0]       size_q, size_d;
    logic [LEN_WIDTH-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-LEAD_W-1:0] carry_q, carry_d;
    logic [CARRY_BYTES-1:0]     ckeep_q, ckeep_d;

    logic                       vld_q, last_q, err_q;
    logic [DATA_WIDTH-1:0]      data_q;
    logic [KEEP_WIDTH-1:0]      keep_q;

    logic                       out_load, s_fire;
    logic [DATA_WIDTH-1:0]      s_data_m;
    logic [LEN_WIDTH-1:0]       cnt_acc;
    logic [79:0]                recon_hdr;
    logic [DATA_WIDTH-LEAD_W-1:0] hdr_blk;
    logic                       beat_vld, beat_last, beat_err;
    logic [DATA_WIDTH-1:0]      beat_data;
    logic [KEEP_WIDTH-1:0]      beat_keep;

    function automatic logic [DATA_WIDTH-1:0] mask_bytes(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [KEEP_WIDTH-1:0] k);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) r[i*8 +: 8] = k[i] ? d[i*8 +: 8] : 8'h00;
        return r;
    endfunction

    function automatic logic [LEN_WIDTH-1:0] popcnt(input logic [KEEP_WIDTH-1:0] k);
        logic [LEN_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) n = n + LEN_WIDTH'(k[i]);
        return n;
    endfunction

    // Handshakes, masked input data, and the fixed 56-byte header block.
    always_comb begin
        out_load      = !vld_q || m_axis_tready;
        s_axis_tready = !rst && ((state_q == HDR && size_q != '0) || state_q == BODY) && out_load;
        s_fire        = s_axis_tvalid && s_axis_tready;
        cmd_ready     = !rst && (state_q == IDLE);
        s_data_m      = mask_bytes(s_axis_tdata, s_axis_tkeep);
        cnt_acc       = cnt_q + popcnt(s_axis_tkeep);
        recon_hdr     = {3'b000, size_q, id_q, addr_q, 1'b1, func_q};
        hdr_blk       = {recon_hdr, tmpl_q};
    end

    // Next-state, command latch, carry update and output beat assembly.
    always_comb begin
        state_d   = state_q;
        tmpl_d    = tmpl_q;
        func_d    = func_q;
        id_d      = id_q;
        addr_d    = addr_q;
        size_d    = size_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        ckeep_d   = ckeep_q;
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        beat_err  = 1'b0;
        beat_data = '0;
        beat_keep = '0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    tmpl_d  = hdr_template;
                    func_d  = cmd_func;
                    id_d    = cmd_id;
                    addr_d  = cmd_addr;
                    size_d  = cmd_size;
                    cnt_d   = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (size_q == '0) begin
                    if (out_load) begin
                        beat_vld  = 1'b1;
                        beat_data = {{LEAD_W{1'b0}}, hdr_blk};
                        beat_keep = {{LEAD_BYTES{1'b0}}, {CARRY_BYTES{1'b1}}};
                        beat_last = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (s_fire) begin
                    beat_vld  = 1'b1;
                    beat_data = {s_data_m[LEAD_W-1:0], hdr_blk};
                    beat_keep = {s_axis_tkeep[LEAD_BYTES-1:0], {CARRY_BYTES{1'b1}}};
                end
            end
            BODY: begin
                if (s_fire) begin
                    beat_vld  = 1'b1;
                    beat_data = {s_data_m[LEAD_W-1:0], carry_q};
                    beat_keep = {s_axis_tkeep[LEAD_BYTES-1:0], ckeep_q};
                end
            end
            TAIL: begin
                if (out_load) begin
                    beat_vld  = 1'b1;
                    beat_data = {{LEAD_W{1'b0}}, carry_q};
                    beat_keep = {{LEAD_BYTES{1'b0}}, ckeep_q};
                    beat_last = 1'b1;
                    beat_err  = (cnt_q != size_q);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Common payload-beat bookkeeping for HDR and BODY.
        if (s_fire) begin
            cnt_d   = cnt_acc;
            carry_d = s_data_m[DATA_WIDTH-1:LEAD_W];
            ckeep_d = s_axis_tkeep[KEEP_WIDTH-1:LEAD_BYTES];
            if (!s_axis_tlast) begin
                state_d = BODY;
            end else if (s_axis_tkeep[KEEP_WIDTH-1:LEAD_BYTES] == '0) begin
                beat_last = 1'b1;
                beat_err  = (cnt_acc != size_q);
                state_d   = IDLE;
            end else begin
                state_d = TAIL;
            end
        end
    end

    // FSM state, latched command context, byte counter and carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmpl_q  <= '0;
            func_q  <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            carry_q <= '0;
            ckeep_q <= '0;
        end else begin
            state_q <= state_d;
            tmpl_q  <= tmpl_d;
            func_q  <= func_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ckeep_q <= ckeep_d;
        end
    end

    // Output register stage; holds while the sink stalls. len_err pulses once,
    // in the cycle the tlast beat is first presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (out_load) begin
                vld_q  <= beat_vld;
                data_q <= beat_data;
                keep_q <= beat_keep;
                last_q <= beat_last;
            end
            err_q <= beat_err;
        end
    end

    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = last_q;
    assign len_err       = err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_recon_tx_framer.sv
// Bench for recon_tx_framer: random payloads against a byte-stream frame model.
module tb_recon_tx_framer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [367:0] hdr_template = '0;
    logic [1:0]   cmd_func = '0;
    logic [7:0]   cmd_id = '0;
    logic [33:0]  cmd_addr = '0;
    logic [31:0]  cmd_size = '0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic         len_err;
    logic         busy;

    recon_tx_framer dut (
        .clk(clk), .rst(rst), .hdr_template(hdr_template),
        .cmd_func(cmd_func), .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .len_err(len_err), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired, sim time limit reached");
        $fatal(1, "watchdog");
    end

    int vectors = 0;
    int errors  = 0;
    int tr_mode = 0;

    // Sink ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
    initial begin
        int ph;
        ph = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (tr_mode)
                0: m_axis_tready = 1'b1;
                1: begin m_axis_tready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: logs every accepted output beat with its cycle, payload accept
    // cycles, command accept cycle, len_err pulses and stall-stability breaks.
    logic [511:0] got_data[$];
    logic [63:0]  got_keep[$];
    bit           got_last[$];
    int           got_cyc[$];
    int           s_cyc[$];
    int           cyc = 0, acc_cyc = 0, frames_done = 0;
    int           le_cnt = 0, le_on_last = 0, stall_viol = 0;
    logic [511:0] pd;
    logic [63:0]  pk;
    logic         pl;
    bit           stall_prev = 0;

    always @(negedge clk) begin
        cyc++;
        if (stall_prev && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd ||
                           m_axis_tkeep !== pk || m_axis_tlast !== pl)) stall_viol++;
        stall_prev = m_axis_tvalid && !m_axis_tready && !rst;
        pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast;
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (s_axis_tvalid && s_axis_tready) s_cyc.push_back(cyc);
        if (len_err) begin
            le_cnt++;
            if (m_axis_tvalid && m_axis_tlast) le_on_last++;
        end
        if (m_axis_tvalid && m_axis_tready && !rst) begin
            got_data.push_back(m_axis_tdata);
            got_keep.push_back(m_axis_tkeep);
            got_last.push_back(m_axis_tlast);
            got_cyc.push_back(cyc);
            if (m_axis_tlast) frames_done++;
        end
    end

    // Expected frame (filled by send_frame) and monitor baselines for it.
    logic [511:0] exp_data[$];
    logic [63:0]  exp_keep[$];
    bit           exp_last[$];
    bit           exp_err;
    int           gbase, sbase, le_base, lel_base, sv_base, fd_base;

    // Reference model: the frame is a flat byte string (template, recon header
    // with fields at their bit offsets, then payload) cut into 64-byte beats.
    task automatic build_expect(input logic [367:0] tmpl, input logic [1:0] f, input logic [7:0] id,
                                input logic [33:0] a, input logic [31:0] sz, input byte unsigned pay[$]);
        byte unsigned fb[$];
        logic [79:0]  rh;
        logic [511:0] d;
        logic [63:0]  k;
        rh = 80'(f) | (80'd1 << 2) | (80'(a) << 3) | (80'(id) << 37) | (80'(sz) << 45);
        for (int i = 0; i < 46; i++) fb.push_back(tmpl[i*8 +: 8]);
        for (int i = 0; i < 10; i++) fb.push_back(rh[i*8 +: 8]);
        if (sz != 0) foreach (pay[i]) fb.push_back(pay[i]);
        exp_data.delete(); exp_keep.delete(); exp_last.delete();
        for (int b = 0; b * 64 < fb.size(); b++) begin
            d = '0; k = '0;
            for (int j = 0; j < 64; j++)
                if (b * 64 + j < fb.size()) begin d[j*8 +: 8] = fb[b*64 + j]; k[j] = 1'b1; end
            exp_data.push_back(d); exp_keep.push_back(k); exp_last.push_back((b + 1) * 64 >= fb.size());
        end
        exp_err = (sz != 0) && (32'(pay.size()) != sz);
    endtask

    // Drive one command plus its payload (n random bytes, partial last beat with
    // garbage above tkeep) and wait, bounded, for the frame's tlast beat.
    task automatic send_frame(input logic [1:0] f, input logic [7:0] id, input logic [33:0] a,
                              input logic [31:0] sz, input int n, input bit gaps);
        byte unsigned pay[$];
        logic [511:0] in_data[$];
        logic [63:0]  in_keep[$];
        logic [383:0] t;
        logic [511:0] d;
        logic [63:0]  k;
        int           tc, tw;
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
        for (int w = 0; w < 12; w++) t[w*32 +: 32] = $urandom;
        build_expect(t[367:0], f, id, a, sz, pay);
        if (sz != 0)
            for (int b = 0; b * 64 < n; b++) begin
                for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
                k = '0;
                for (int j = 0; j < 64; j++)
                    if (b * 64 + j < n) begin d[j*8 +: 8] = pay[b*64 + j]; k[j] = 1'b1; end
                in_data.push_back(d); in_keep.push_back(k);
            end
        gbase = got_data.size(); sbase = s_cyc.size(); le_base = le_cnt;
        lel_base = le_on_last; sv_base = stall_viol; fd_base = frames_done;
        @(posedge clk); #1;
        hdr_template = t[367:0]; cmd_func = f; cmd_id = id; cmd_addr = a; cmd_size = sz; cmd_valid = 1'b1;
        tc = 0;
        do begin @(negedge clk); tc++; end while (!cmd_ready && tc < 200);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int w = 0; w < 12; w++) t[w*32 +: 32] = $urandom;
        hdr_template = t[367:0];
        fork
            begin
                int tt;
                for (int b = 0; b < in_data.size(); b++) begin
                    s_axis_tdata = in_data[b]; s_axis_tkeep = in_keep[b];
                    s_axis_tlast = (b == in_data.size() - 1); s_axis_tvalid = 1'b1;
                    tt = 0;
                    do begin @(negedge clk); tt++; end while (!s_axis_tready && tt < 3000);
                    @(posedge clk); #1;
                    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
                    if (tt >= 3000) break;
                    if (gaps && $urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
                end
            end
            begin
                tw = 0;
                while (frames_done == fd_base && tw < 4000) begin @(posedge clk); tw++; end
            end
        join
        if (frames_done == fd_base) begin
            errors++;
            $display("FAIL frame_timeout no tlast beat seen, beats=%0d required=%0d", got_data.size() - gbase, exp_data.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({m_axis_tvalid, m_axis_tlast, len_err, busy, cmd_ready, s_axis_tready} !== 6'b0 ||
            m_axis_tdata !== '0 || m_axis_tkeep !== '0) begin
            errors++;
            $display("FAIL reset_outputs vld=%b last=%b err=%b busy=%b crdy=%b srdy=%b keep=%h required all 0",
                     m_axis_tvalid, m_axis_tlast, len_err, busy, cmd_ready, s_axis_tready, m_axis_tkeep);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release crdy=%b busy=%b srdy=%b required 1 0 0", cmd_ready, busy, s_axis_tready);
        end
    endtask

    task automatic test_header_only();
        tr_mode = 0;
        send_frame(2'd1, 8'h5A, 34'h2_0000_1000, 32'd0, 0, 1'b0);
        vectors++;
        if (got_data.size() - gbase != exp_data.size()) begin
            errors++; $display("FAIL hdr_only beats got=%0d required=%0d", got_data.size() - gbase, exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && gbase + i < got_data.size(); i++) begin
            vectors++;
            if (got_data[gbase+i] !== exp_data[i] || got_keep[gbase+i] !== exp_keep[i] || got_last[gbase+i] !== exp_last[i]) begin
                errors++;
                $display("FAIL hdr_only beat%0d keep=%h last=%b data=%h required keep=%h last=%b data=%h",
                         i, got_keep[gbase+i], got_last[gbase+i], got_data[gbase+i], exp_keep[i], exp_last[i], exp_data[i]);
            end
        end
        if (got_data.size() > gbase) begin
            vectors++;
            if (got_keep[gbase] !== 64'h00FF_FFFF_FFFF_FFFF) begin
                errors++; $display("FAIL hdr_only_keep got=%h required=00ffffffffffffff", got_keep[gbase]);
            end
            vectors++;
            if (got_cyc[gbase] - acc_cyc != 2) begin
                errors++; $display("FAIL hdr_only_latency got=%0d required=2", got_cyc[gbase] - acc_cyc);
            end
        end
        vectors++;
        if (le_cnt != le_base) begin errors++; $display("FAIL hdr_only_len_err pulses=%0d required=0", le_cnt - le_base); end
    endtask

    task automatic test_short_payload();
        tr_mode = 0;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b1; s_axis_tkeep = '1;
        @(negedge clk);
        vectors++;
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL idle_tready got=%b required=0", s_axis_tready); end
        @(posedge clk); #1; s_axis_tvalid = 1'b0;
        send_frame(2'd2, 8'h11, 34'h0_0000_0040, 32'd8, 8, 1'b0);
        vectors++;
        if (got_data.size() - gbase != exp_data.size()) begin
            errors++; $display("FAIL pay8 beats got=%0d required=%0d", got_data.size() - gbase, exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && gbase + i < got_data.size(); i++) begin
            vectors++;
            if (got_data[gbase+i] !== exp_data[i] || got_keep[gbase+i] !== exp_keep[i] || got_last[gbase+i] !== exp_last[i]) begin
                errors++;
                $display("FAIL pay8 beat%0d keep=%h last=%b data=%h required keep=%h last=%b data=%h",
                         i, got_keep[gbase+i], got_last[gbase+i], got_data[gbase+i], exp_keep[i], exp_last[i], exp_data[i]);
            end
        end
        if (got_data.size() > gbase && s_cyc.size() > sbase) begin
            vectors++;
            if (got_cyc[gbase] - s_cyc[sbase] != 1) begin
                errors++; $display("FAIL pay8_latency got=%0d required=1", got_cyc[gbase] - s_cyc[sbase]);
            end
        end
        vectors++;
        if (le_cnt != le_base) begin errors++; $display("FAIL pay8_len_err pulses=%0d required=0", le_cnt - le_base); end
    endtask

    task automatic test_multi_beat();
        int nb;
        tr_mode = 0;
        send_frame(2'd3, 8'hC3, 34'h1_2345_6780, 32'd100, 100, 1'b0);
        nb = got_data.size() - gbase;
        vectors++;
        if (nb != 3) begin errors++; $display("FAIL pay100 beats got=%0d required=3", nb); end
        for (int i = 0; i < exp_data.size() && i < nb; i++) begin
            vectors++;
            if (got_data[gbase+i] !== exp_data[i] || got_keep[gbase+i] !== exp_keep[i] || got_last[gbase+i] !== exp_last[i]) begin
                errors++;
                $display("FAIL pay100 beat%0d keep=%h last=%b data=%h required keep=%h last=%b data=%h",
                         i, got_keep[gbase+i], got_last[gbase+i], got_data[gbase+i], exp_keep[i], exp_last[i], exp_data[i]);
            end
        end
        if (nb == 3) begin
            vectors++;
            if (got_keep[gbase+2] !== 64'h0000_0000_0FFF_FFFF) begin
                errors++; $display("FAIL pay100_tail_keep got=%h required=000000000fffffff", got_keep[gbase+2]);
            end
            vectors++;
            if (got_cyc[gbase+2] - got_cyc[gbase] != 2) begin
                errors++; $display("FAIL pay100_throughput span=%0d required=2", got_cyc[gbase+2] - got_cyc[gbase]);
            end
        end
    endtask

    task automatic test_backpressure();
        tr_mode = 1;
        send_frame(2'd0, 8'h77, 34'h3_0000_0000, 32'd256, 256, 1'b0);
        vectors++;
        if (got_data.size() - gbase != exp_data.size()) begin
            errors++; $display("FAIL bp beats got=%0d required=%0d", got_data.size() - gbase, exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && gbase + i < got_data.size(); i++) begin
            vectors++;
            if (got_data[gbase+i] !== exp_data[i] || got_keep[gbase+i] !== exp_keep[i] || got_last[gbase+i] !== exp_last[i]) begin
                errors++;
                $display("FAIL bp beat%0d keep=%h last=%b data=%h required keep=%h last=%b data=%h",
                         i, got_keep[gbase+i], got_last[gbase+i], got_data[gbase+i], exp_keep[i], exp_last[i], exp_data[i]);
            end
        end
        vectors++;
        if (stall_viol != sv_base) begin errors++; $display("FAIL bp_stable breaks=%0d required=0", stall_viol - sv_base); end
        tr_mode = 0;
    endtask

    task automatic test_len_mismatch();
        tr_mode = 0;
        send_frame(2'd1, 8'h22, 34'h0_0001_0000, 32'd128, 120, 1'b0);
        vectors++;
        if (got_data.size() - gbase != exp_data.size()) begin
            errors++; $display("FAIL lenerr beats got=%0d required=%0d", got_data.size() - gbase, exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && gbase + i < got_data.size(); i++) begin
            vectors++;
            if (got_data[gbase+i] !== exp_data[i] || got_keep[gbase+i] !== exp_keep[i] || got_last[gbase+i] !== exp_last[i]) begin
                errors++;
                $display("FAIL lenerr beat%0d keep=%h last=%b data=%h required keep=%h last=%b data=%h",
                         i, got_keep[gbase+i], got_last[gbase+i], got_data[gbase+i], exp_keep[i], exp_last[i], exp_data[i]);
            end
        end
        vectors++;
        if (le_cnt - le_base != 1 || le_on_last - lel_base != 1) begin
            errors++;
            $display("FAIL lenerr_pulse pulses=%0d on_last=%0d required 1 1", le_cnt - le_base, le_on_last - lel_base);
        end
    endtask

    task automatic test_reset_mid_frame();
        int tc;
        int fd0;
        tr_mode = 0;
        fd0 = frames_done;
        @(posedge clk); #1;
        cmd_func = 2'd2; cmd_id = 8'h99; cmd_addr = 34'h0_0000_8000; cmd_size = 32'd320; cmd_valid = 1'b1;
        tc = 0;
        do begin @(negedge clk); tc++; end while (!cmd_ready && tc < 200);
        @(posedge clk); #1; cmd_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 16; w++) s_axis_tdata[w*32 +: 32] = $urandom;
            s_axis_tkeep = '1; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
            tc = 0;
            do begin @(negedge clk); tc++; end while (!s_axis_tready && tc < 200);
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b0 || s_axis_tready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ready crdy=%b srdy=%b required 0 0", cmd_ready, s_axis_tready);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || len_err !== 1'b0 || frames_done != fd0) begin
            errors++;
            $display("FAIL rst_mid_state vld=%b busy=%b err=%b tlast_frames=%0d required 0 0 0 0",
                     m_axis_tvalid, busy, len_err, frames_done - fd0);
        end
        send_frame(2'd1, 8'h3C, 34'h2_AAAA_5555, 32'd0, 0, 1'b0);
        vectors++;
        if (got_data.size() - gbase != exp_data.size()) begin
            errors++; $display("FAIL rst_hdr beats got=%0d required=%0d", got_data.size() - gbase, exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && gbase + i < got_data.size(); i++) begin
            vectors++;
            if (got_data[gbase+i] !== exp_data[i] || got_keep[gbase+i] !== exp_keep[i] || got_last[gbase+i] !== exp_last[i]) begin
                errors++;
                $display("FAIL rst_hdr beat%0d keep=%h last=%b data=%h required keep=%h last=%b data=%h",
                         i, got_keep[gbase+i], got_last[gbase+i], got_data[gbase+i], exp_keep[i], exp_last[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        logic [31:0] sz;
        tr_mode = 2;
        for (int fr = 0; fr < 10; fr++) begin
            n = $urandom_range(1, 300);
            case ($urandom_range(0, 5))
                0: sz = 32'd0;
                1: sz = 32'(n + $urandom_range(1, 70));
                2: sz = 32'(n - $urandom_range(1, n));
                default: sz = 32'(n);
            endcase
            send_frame(2'($urandom), 8'($urandom), 34'({$urandom, $urandom}), sz, n, 1'($urandom_range(0, 1)));
            vectors++;
            if (got_data.size() - gbase != exp_data.size()) begin
                errors++; $display("FAIL rand%0d beats got=%0d required=%0d", fr, got_data.size() - gbase, exp_data.size());
            end
            for (int i = 0; i < exp_data.size() && gbase + i < got_data.size(); i++) begin
                vectors++;
                if (got_data[gbase+i] !== exp_data[i] || got_keep[gbase+i] !== exp_keep[i] || got_last[gbase+i] !== exp_last[i]) begin
                    errors++;
                    $display("FAIL rand%0d beat%0d keep=%h last=%b data=%h required keep=%h last=%b data=%h", fr,
                             i, got_keep[gbase+i], got_last[gbase+i], got_data[gbase+i], exp_keep[i], exp_last[i], exp_data[i]);
                end
            end
            vectors++;
            if (le_cnt - le_base != int'(exp_err) || stall_viol != sv_base) begin
                errors++;
                $display("FAIL rand%0d_err_stable pulses=%0d breaks=%0d required %0d 0", fr,
                         le_cnt - le_base, stall_viol - sv_base, int'(exp_err));
            end
        end
        tr_mode = 0;
    endtask

    initial begin
        test_reset();
        test_header_only();
        test_short_payload();
        test_multi_beat();
        test_backpressure();
        test_len_mismatch();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
